// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage MIPS pipeline.
//
// This stage sits directly downstream of the EX/MEM register. It does the
// following:
//   - performs word loads and stores against an internal word-addressed RAM
//     that takes LATENCY cycles per access;
//   - stalls the upstream stages while an access is in progress;
//   - resolves the branch decision for the instruction in MEM;
//   - registers the results into the MEM/WB boundary.
//
// Parameters
//   DEPTH    data memory size in 32-bit words (power of 2)
//   LATENCY  cycles per load/store access (>= 1)
//
// Ports
//   clk, reset                     clock; asynchronous active-low reset
//   ctrl_*_ex_mem                  control bits from EX/MEM
//   zero_ex_mem                    ALU zero flag
//   branch_or_not_address_ex_mem   branch target
//   alu_result_ex_mem              ALU result / byte address
//   read_data_2_ex_mem             store data
//   write_register_ex_mem          destination register
//   pc_src, branch_target          branch decision (combinational)
//   mem_stall                      freeze IF/ID/EX and EX/MEM (combinational)
//   misalign_err                   one-cycle pulse after a misaligned access
//   *_mem_wb                       registered MEM/WB fields
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_regWrite_ex_mem,
  input  logic        ctrl_memToReg_ex_mem,
  input  logic        ctrl_branch_ex_mem,
  input  logic        ctrl_memRead_ex_mem,
  input  logic        ctrl_memWrite_ex_mem,
  input  logic        zero_ex_mem,
  input  logic [31:0] branch_or_not_address_ex_mem,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] read_data_2_ex_mem,
  input  logic [4:0]  write_register_ex_mem,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_register_mem_wb
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam bit MULTI = (LATENCY > 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       ram [DEPTH];

  logic              mem_op;
  logic              misaligned;
  logic              req;
  logic              is_store;
  logic              is_load;
  logic              complete;
  logic              stall_int;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  // Decode of the EX/MEM instruction
  assign mem_op     = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign misaligned = mem_op & (alu_result_ex_mem[1:0] != 2'b00);
  assign req        = mem_op & ~misaligned;
  // A read+write combination is treated as a plain store.
  assign is_store   = ctrl_memWrite_ex_mem;
  assign is_load    = ctrl_memRead_ex_mem & ~ctrl_memWrite_ex_mem;
  // Upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign word_idx         = alu_result_ex_mem[ADDR_W+1:2];
  assign unused_addr_bits = ^alu_result_ex_mem[31:ADDR_W+2];

  // An access completes in the cycle where the counter reaches its last
  // value. A single-cycle memory completes in the same cycle it is seen.
  assign complete  = req & ((state == IDLE) ? !MULTI : (cnt == CNT_LAST));
  assign stall_int = req & ~complete;

  // The reset term is kept off the internal stall path on purpose. That way
  // the asynchronous reset never feeds the D inputs of the flops.
  assign mem_stall     = reset & stall_int;
  assign pc_src        = reset & ctrl_branch_ex_mem & zero_ex_mem;
  assign branch_target = branch_or_not_address_ex_mem;

  // Access sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (req && MULTI) begin
        state <= ACCESS;
        cnt   <= CNT_W'(1);
      end
    end else begin
      // Dropping the request mid-access returns to IDLE. This keeps the
      // sequencer from locking up if the inputs are not held stable.
      if (!req || (cnt == CNT_LAST)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  // Data memory: written only on the completion edge, so a store that is
  // cut short by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (complete && is_store) begin
      ram[word_idx] <= read_data_2_ex_mem;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_regWrite_mem_wb  <= 1'b0;
      ctrl_memToReg_mem_wb  <= 1'b0;
      read_data_mem_wb      <= '0;
      alu_result_mem_wb     <= '0;
      write_register_mem_wb <= '0;
      misalign_err          <= 1'b0;
    end else begin
      misalign_err <= misaligned;
      if (stall_int) begin
        // Bubble into WB while the access is still in flight.
        ctrl_regWrite_mem_wb <= 1'b0;
        ctrl_memToReg_mem_wb <= 1'b0;
      end else begin
        ctrl_regWrite_mem_wb  <= ctrl_regWrite_ex_mem & ~misaligned;
        ctrl_memToReg_mem_wb  <= ctrl_memToReg_ex_mem;
        alu_result_mem_wb     <= alu_result_ex_mem;
        write_register_mem_wb <= write_register_ex_mem;
        read_data_mem_wb      <= (complete && is_load) ? ram[word_idx] : '0;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM register. It performs data-memory loads and stores against an internal word-addressed RAM with a configurable multi-cycle access latency, and stalls upstream stages while an access is in progress. It resolves the branch decision for the instruction in MEM and registers results into the MEM/WB boundary for write-back.

## Interface
- DEPTH, 256: data memory size in 32-bit words (power of 2); ADDR_W = log2(DEPTH)
- LATENCY, 3: cycles per load/store access, >= 1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem, ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem  in  1 each  control bits from EX/MEM
- zero_ex_mem  in  1  ALU zero flag
- branch_or_not_address_ex_mem  in  32  branch target
- alu_result_ex_mem  in  32  ALU result / byte address
- read_data_2_ex_mem  in  32  store data
- write_register_ex_mem  in  5  destination register
- pc_src  out  1  branch taken (combinational)
- branch_target  out  32  = branch_or_not_address_ex_mem (combinational)
- mem_stall  out  1  freeze IF/ID/EX and EX/MEM (combinational)
- misalign_err  out  1  registered one-cycle pulse, misaligned access
- ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb  out  1 each  registered control to WB
- read_data_mem_wb  out  32  registered load data
- alu_result_mem_wb  out  32  registered ALU result
- write_register_mem_wb  out  5  registered destination

## Operation
- req = (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem) & alu_result_ex_mem[1:0]==0; word index = alu_result_ex_mem[ADDR_W+1:2]; upper bits ignored (address wraps modulo DEPTH).
- memRead and memWrite both set: treated as a store; read_data_mem_wb = 0.
- Misaligned (memRead|memWrite with addr[1:0]!=0): no memory access, no stall, misalign_err=1 next cycle, MEM/WB captures with ctrl_regWrite forced 0.
- FSM: IDLE, ACCESS; counter cnt 0..LATENCY-1.
  - IDLE: req & LATENCY>1 -> ACCESS, cnt=1; req & LATENCY==1 -> complete this cycle, stay IDLE.
  - ACCESS: cnt++ each cycle; at cnt==LATENCY-1 complete, -> IDLE, cnt=0.
- mem_stall = req & (IDLE ? LATENCY>1 : cnt!=LATENCY-1).
- Completion edge: store writes read_data_2_ex_mem into RAM; load captures RAM[index] into read_data_mem_wb; MEM/WB captures all fields.
- Stall edges: MEM/WB captures a bubble (ctrl_regWrite_mem_wb=0, ctrl_memToReg_mem_wb=0); other MEM/WB fields hold. Inputs required stable while mem_stall=1.
- No memory op: MEM/WB captures inputs every cycle, read_data_mem_wb = 0.
- pc_src = reset & ctrl_branch_ex_mem & zero_ex_mem; independent of FSM.
- RAM contents not cleared by reset.

## Timing
- Reset (async, low): state IDLE, cnt 0, all registered outputs 0, in-flight store aborted (RAM unchanged); mem_stall=0 and pc_src=0 while reset low.
- Load/store latency LATENCY cycles from first cycle req seen to MEM/WB update; mem_stall high for LATENCY-1 of those cycles, low in the final one.
- Back-to-back accesses: next request begins in the cycle after completion; no idle gap.
- Non-memory instruction: one cycle to MEM/WB.
- misalign_err high exactly one cycle after the offending cycle.

## Test plan
- LATENCY=3: store 0xDEADBEEF at addr 0x10, then load 0x10 -> mem_stall high 2 cycles per access, read_data_mem_wb=0xDEADBEEF, ctrl_regWrite_mem_wb=1 only on completion edge.
- LATENCY=1: load/store/load back-to-back -> mem_stall never high, one result per cycle, store visible to following load.
- branch=1, zero=1, target 0x40 -> pc_src=1, branch_target=0x40 same cycle; zero=0 -> pc_src=0.
- Load at addr 0x12 -> no stall, misalign_err pulse 1 cycle, ctrl_regWrite_mem_wb=0, RAM unchanged.
- Store to 0x20 with reset asserted at cnt=1 -> all outputs 0 immediately, state IDLE, later load of 0x20 returns prior value.
- Address DEPTH*4+8 -> aliases to word 2; R-type ALU 0x1234 -> alu_result_mem_wb=0x1234 next cycle, read_data_mem_wb=0.
